// File: rtl/ssd_scan.sv
// Multiplexed hex seven-segment scanner with frame-aligned double-buffered load.
// Latency: outputs are registered, one cycle behind cnt/idx/active data; committed data appears the frame after load.
// Backpressure: none, load is always accepted; optional leading-zero blanking via SSD_LZB_EN.
module ssd_scan #(
    parameter int NDIGITS  = 4,
    parameter int SCAN_DIV = 1000,
    parameter int GUARD    = 2
) (
    input  logic                   clk,
    input  logic                   nrst,
    input  logic                   enable,
    input  logic                   load,
    input  logic [4*NDIGITS-1:0]   value,
    input  logic [NDIGITS-1:0]     blank,
    input  logic [NDIGITS-1:0]     dp,
    output logic [6:0]             seg,
    output logic                   dp_out,
    output logic [NDIGITS-1:0]     an,
    output logic                   frame_done
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] LIT_END  = CW'(SCAN_DIV - GUARD);
    localparam logic [IW-1:0] IDX_LAST = IW'(NDIGITS - 1);

    logic [CW-1:0]          cnt;
    logic [IW-1:0]          idx;
    logic                   cnt_wrap;
    logic                   boundary;

    logic [4*NDIGITS-1:0]   pend_val;
    logic [NDIGITS-1:0]     pend_blank;
    logic [NDIGITS-1:0]     pend_dp;
    logic                   pend_vld;
    logic [4*NDIGITS-1:0]   act_val;
    logic [NDIGITS-1:0]     act_blank;
    logic [NDIGITS-1:0]     act_dp;

    logic [3:0]             cur_nib;
    logic                   cur_blank;
    logic                   cur_dp;
    logic                   lz_dark;
    logic                   dark;
    logic [6:0]             glyph;
    logic [NDIGITS-1:0]     an_sel;

    assign cnt_wrap = (cnt == CNT_LAST);
    assign boundary = cnt_wrap && (idx == IDX_LAST);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt <= '0;
            idx <= '0;
        end else if (cnt_wrap) begin
            cnt <= '0;
            idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // A load on the boundary edge lands in pending while the old pending commits.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            pend_val   <= '0;
            pend_blank <= '0;
            pend_dp    <= '0;
            pend_vld   <= 1'b0;
            act_val    <= '0;
            act_blank  <= '0;
            act_dp     <= '0;
        end else begin
            if (boundary && pend_vld) begin
                act_val   <= pend_val;
                act_blank <= pend_blank;
                act_dp    <= pend_dp;
            end
            if (load) begin
                pend_val   <= value;
                pend_blank <= blank;
                pend_dp    <= dp;
                pend_vld   <= 1'b1;
            end else if (boundary) begin
                pend_vld   <= 1'b0;
            end
        end
    end

    always_comb begin
        cur_nib   = '0;
        cur_blank = 1'b0;
        cur_dp    = 1'b0;
        an_sel    = '0;
        for (int k = 0; k < NDIGITS; k++) begin
            if (idx == IW'(k)) begin
                cur_nib   = act_val[4*k +: 4];
                cur_blank = act_blank[k];
                cur_dp    = act_dp[k];
                an_sel[k] = 1'b1;
            end
        end
    end

`ifdef SSD_LZB_EN
    logic zero_run;

    // Walk down from the top digit; digit 0 is never reached so it always shows.
    always_comb begin
        lz_dark  = 1'b0;
        zero_run = 1'b1;
        for (int k = NDIGITS - 1; k >= 1; k--) begin
            zero_run = zero_run && (act_val[4*k +: 4] == 4'h0);
            if (idx == IW'(k)) begin
                lz_dark = zero_run;
            end
        end
    end
`else
    assign lz_dark = 1'b0;
`endif

    always_comb begin
        case (cur_nib)
            4'h0:    glyph = 7'h3F;
            4'h1:    glyph = 7'h06;
            4'h2:    glyph = 7'h5B;
            4'h3:    glyph = 7'h4F;
            4'h4:    glyph = 7'h66;
            4'h5:    glyph = 7'h6D;
            4'h6:    glyph = 7'h7D;
            4'h7:    glyph = 7'h07;
            4'h8:    glyph = 7'h7F;
            4'h9:    glyph = 7'h67;
            4'hA:    glyph = 7'h77;
            4'hB:    glyph = 7'h7C;
            4'hC:    glyph = 7'h39;
            4'hD:    glyph = 7'h5E;
            4'hE:    glyph = 7'h79;
            default: glyph = 7'h71;
        endcase
    end

    assign dark = !enable || cur_blank || lz_dark;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            seg        <= '0;
            dp_out     <= 1'b0;
            an         <= '0;
            frame_done <= 1'b0;
        end else begin
            seg        <= dark ? 7'h00 : glyph;
            dp_out     <= !dark && cur_dp;
            an         <= (enable && (cnt < LIT_END)) ? an_sel : '0;
            frame_done <= boundary;
        end
    end

endmodule

// File: tb/tb_ssd_scan.sv
// Directed bench for ssd_scan at NDIGITS=4, SCAN_DIV=8, GUARD=2; frames are 32 cycles.
module tb_ssd_scan;

    logic        clk;
    logic        nrst;
    logic        enable;
    logic        load;
    logic [15:0] value;
    logic [3:0]  blank;
    logic [3:0]  dp;
    logic [6:0]  seg;
    logic        dp_out;
    logic [3:0]  an;
    logic        frame_done;

    int vectors;
    int miscompares;

`ifdef SSD_LZB_EN
    localparam logic [27:0] ZERO_SEGS = {7'h00, 7'h00, 7'h00, 7'h3F};
    localparam logic [13:0] HI_0050   = {7'h00, 7'h00};
`else
    localparam logic [27:0] ZERO_SEGS = {7'h3F, 7'h3F, 7'h3F, 7'h3F};
    localparam logic [13:0] HI_0050   = {7'h3F, 7'h3F};
`endif
    localparam logic [23:0] NO_LOAD = 24'h0;

    ssd_scan #(.NDIGITS(4), .SCAN_DIV(8), .GUARD(2)) dut (
        .clk        (clk),
        .nrst       (nrst),
        .enable     (enable),
        .load       (load),
        .value      (value),
        .blank      (blank),
        .dp         (dp),
        .seg        (seg),
        .dp_out     (dp_out),
        .an         (an),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one aligned 32-cycle frame; outputs seen after tick j reflect frame position j.
    // ld words are {dp, blank, value}; ld_at of -1 means no load.
    task automatic check_frame(input string name, input logic [27:0] segs, input logic [3:0] dps,
                               input logic en_start, input int en_off_at,
                               input int ld1_at, input logic [23:0] ld1,
                               input int ld2_at, input logic [23:0] ld2);
        logic [3:0] exp_an;
        logic       en_now;
        int         c;
        int         i;
        for (int j = 0; j < 32; j++) begin
            en_now = (j >= en_off_at) ? 1'b0 : en_start;
            enable = en_now;
            if (j == ld1_at) begin
                load = 1'b1;
                {dp, blank, value} = ld1;
            end else if (j == ld2_at) begin
                load = 1'b1;
                {dp, blank, value} = ld2;
            end else begin
                load = 1'b0;
            end
            tick();
            c = j % 8;
            i = j / 8;
            exp_an = (en_now && c < 6) ? (4'b0001 << i) : 4'b0000;
            vectors++;
            if (an !== exp_an) begin
                miscompares++;
                $display("FAIL %s an pos=%0d got=%b want=%b", name, j, an, exp_an);
            end
            vectors++;
            if (frame_done !== (j == 31)) begin
                miscompares++;
                $display("FAIL %s frame_done pos=%0d got=%b want=%b", name, j, frame_done, (j == 31));
            end
            if (exp_an != 4'b0000) begin
                vectors++;
                if (seg !== segs[7*i +: 7] || dp_out !== dps[i]) begin
                    miscompares++;
                    $display("FAIL %s seg/dp pos=%0d got=%h/%b want=%h/%b",
                             name, j, seg, dp_out, segs[7*i +: 7], dps[i]);
                end
            end else if (!en_now) begin
                vectors++;
                if (seg !== 7'h00 || dp_out !== 1'b0) begin
                    miscompares++;
                    $display("FAIL %s dark pos=%0d got=%h/%b want=00/0", name, j, seg, dp_out);
                end
            end
        end
        load = 1'b0;
    endtask

    task automatic check_zero_outputs(input string name);
        vectors++;
        if (seg !== 7'h00 || dp_out !== 1'b0 || an !== 4'b0000 || frame_done !== 1'b0) begin
            miscompares++;
            $display("FAIL %s got seg=%h dp=%b an=%b fd=%b want all zero",
                     name, seg, dp_out, an, frame_done);
        end
    endtask

    task automatic test_reset();
        nrst   = 1'b0;
        enable = 1'b1;
        load   = 1'b0;
        value  = '0;
        blank  = '0;
        dp     = '0;
        repeat (3) tick();
        check_zero_outputs("reset");
        nrst = 1'b1;
    endtask

    task automatic test_scan_and_load();
        check_frame("idle_scan", ZERO_SEGS, 4'b0000, 1'b1, 32, 3, {8'h00, 16'h12AF}, -1, NO_LOAD);
        check_frame("load_12AF", {7'h06, 7'h5B, 7'h77, 7'h71}, 4'b0000, 1'b1, 32, -1, NO_LOAD, -1, NO_LOAD);
    endtask

    task automatic test_overwrite();
        check_frame("overwrite_hold", {7'h06, 7'h5B, 7'h77, 7'h71}, 4'b0000, 1'b1, 32,
                    5, {8'h00, 16'h1111}, 20, {8'h00, 16'h2222});
        check_frame("overwrite_2222", {4{7'h5B}}, 4'b0000, 1'b1, 32,
                    10, {8'h00, 16'h3333}, 31, {8'h00, 16'h4444});
    endtask

    task automatic test_back_to_back();
        check_frame("coincide_3333", {4{7'h4F}}, 4'b0000, 1'b1, 32, -1, NO_LOAD, -1, NO_LOAD);
        check_frame("coincide_4444", {4{7'h66}}, 4'b0000, 1'b1, 32, 0, {4'b0010, 4'b0001, 16'h0050}, -1, NO_LOAD);
    endtask

    task automatic test_blank_dp();
        check_frame("blank_dp", {HI_0050, 7'h6D, 7'h00}, 4'b0010, 1'b1, 32, -1, NO_LOAD, -1, NO_LOAD);
    endtask

    task automatic test_enable();
        check_frame("enable_drop", {HI_0050, 7'h6D, 7'h00}, 4'b0010, 1'b1, 12, 14, {8'h00, 16'h5555}, -1, NO_LOAD);
        check_frame("enable_off", {4{7'h00}}, 4'b0000, 1'b0, 32, -1, NO_LOAD, -1, NO_LOAD);
        check_frame("enable_back", {4{7'h6D}}, 4'b0000, 1'b1, 32, -1, NO_LOAD, -1, NO_LOAD);
    endtask

    task automatic test_reset_mid();
        enable = 1'b1;
        for (int j = 0; j <= 12; j++) begin
            load = (j == 2);
            value = 16'h7777;
            tick();
        end
        load = 1'b0;
        vectors++;
        if (an !== 4'b0010 || seg !== 7'h6D) begin
            miscompares++;
            $display("FAIL pre_reset got an=%b seg=%h want an=0010 seg=6D", an, seg);
        end
        #2;
        nrst = 1'b0;
        #1;
        check_zero_outputs("mid_reset_async");
        tick();
        tick();
        check_zero_outputs("mid_reset_held");
        nrst = 1'b1;
        check_frame("after_reset_f0", ZERO_SEGS, 4'b0000, 1'b1, 32, -1, NO_LOAD, -1, NO_LOAD);
        check_frame("after_reset_f1", ZERO_SEGS, 4'b0000, 1'b1, 32, -1, NO_LOAD, -1, NO_LOAD);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_scan_and_load();
        test_overwrite();
        test_back_to_back();
        test_blank_dp();
        test_enable();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
